mdu_unit: RTL
=============

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse from EX stage, sampled on rising edge.
REQ-005 op  input  3  operation: 000 MUL.W, 001 MULH.W, 010 MULH.WU, 100 DIV.W, 101 MOD.W, 110 DIV.WU, 111 MOD.WU, 011 reserved.
REQ-006 src_a  input  32  operand A (selected ALU A operand).
REQ-007 src_b  input  32  operand B (selected ALU B operand).
REQ-008 flush  input  1  pipeline flush; aborts any operation.
REQ-009 busy  output  1  high while an operation is in progress; the pipeline stalls EX on busy.
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 result  output  32  registered result.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE; busy SHALL equal (state != IDLE).
REQ-013 In IDLE, start=1 and flush=0 SHALL latch op, src_a, src_b, clear the 6-bit iteration counter, and enter CALC.
REQ-014 start SHALL be ignored in every state except IDLE; latched operands SHALL NOT change mid-operation.
REQ-015 CALC SHALL perform exactly 32 iterations, one per edge: multiply is radix-2 shift-add on a 64-bit product; divide is restoring division on operand magnitudes.
REQ-016 After the 32nd iteration the state SHALL go to FIX for one cycle (sign correction, result select), then to DONE for one cycle, then to IDLE.
REQ-017 done SHALL rise on the 34th rising edge after the edge that sampled start, stay high exactly one cycle, and result SHALL be valid on that same cycle.
REQ-018 A new start SHALL be accepted no earlier than the first IDLE cycle after DONE (start-to-start period 35 cycles minimum).
REQ-019 MUL.W SHALL return product[31:0]; MULH.W SHALL return signed product[63:32]; MULH.WU SHALL return unsigned product[63:32].
REQ-020 Signed divide SHALL truncate toward zero; remainder sign SHALL follow src_a.
REQ-021 Divide by zero (src_b == 0) SHALL give quotient 0xFFFFFFFF and remainder src_a, for signed and unsigned ops, with the same latency.
REQ-022 DIV.W 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000; MOD.W of the same operands SHALL give 0x00000000.
REQ-023 Reserved op 011 SHALL run the full latency and return 0x00000000.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state with no done pulse; result SHALL keep its previous value.
REQ-025 If flush and start are both high in IDLE, flush SHALL win and no operation SHALL start.
REQ-026 result SHALL hold its value from done until the next DONE state is entered.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0x00000000, counter=0, and latched operands to 0.
REQ-028 Reset deassertion mid-operation SHALL leave the block in IDLE with no done pulse; the aborted operation SHALL NOT resume.

Verification
REQ-029 MULH.W: src_a=0xFFFFFFFE, src_b=0x00000003, start pulse -> busy next cycle, done on 34th edge, result=0xFFFFFFFF; with op MUL.W -> 0xFFFFFFFA.
REQ-030 DIV.W / MOD.W: src_a=0xFFFFFFF9 (-7), src_b=0x00000002 -> 0xFFFFFFFD (-3) / 0xFFFFFFFF (-1); DIV.WU on the same operands -> 0x7FFFFFFC.
REQ-031 Corner: DIV.WU src_b=0 -> 0xFFFFFFFF; MOD.W src_a=0x12345678, src_b=0 -> 0x12345678; DIV.W 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-032 Flush at CALC iteration 10 -> IDLE next edge, busy=0, no done, result unchanged; a start 1 cycle later completes normally.
REQ-033 Start held high continuously for 80 cycles -> exactly two operations, done pulses 35 cycles apart, operands latched at each acceptance.
REQ-034 rst_n asserted during FIX -> busy=0, done=0, result=0x00000000 asynchronously; no done after release.

Source files
------------

// File: rtl/mdu_unit.sv
// Iterative 32-bit multiply/divide unit: 32 shift-add or restoring-divide steps,
// one sign-fix cycle and one result cycle per operation.
module mdu_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_fix;
    logic [31:0] r_result;
    logic        r_done;

    logic        w_accept, w_sgn, w_ge;
    logic [31:0] w_ma, w_mb, w_rsub, w_quo, w_rem, w_fix;
    logic [32:0] w_madd, w_rshift;
    logic [63:0] w_prod, w_prod_s;

    function automatic logic op_signed(input logic [2:0] o);
        return (o == 3'b001) || (o == 3'b100) || (o == 3'b101);
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_CALC;
                S_CALC:  if (r_cnt == 6'd31) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Iteration datapath: r_lo holds the multiplier (mul) or the dividend/quotient (div)
    assign w_sgn    = op_signed(r_op);
    assign w_ma     = mag(r_a, w_sgn);
    assign w_mb     = mag(r_b, w_sgn);
    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, w_ma} : 33'd0);
    assign w_rshift = {r_hi, r_lo[31]};
    assign w_ge     = (w_rshift >= {1'b0, w_mb});
    assign w_rsub   = w_rshift[31:0] - w_mb;

    // Sign correction works on magnitudes; divide-by-zero is overridden explicitly
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (w_sgn && (r_a[31] ^ r_b[31])) ? (~w_prod + 64'd1) : w_prod;
    assign w_quo    = (w_sgn && (r_a[31] ^ r_b[31])) ? (~r_lo + 32'd1) : r_lo;
    assign w_rem    = (w_sgn && r_a[31]) ? (~r_hi + 32'd1) : r_hi;

    always_comb begin
        w_fix = 32'd0;
        case (r_op)
            3'b000:          w_fix = w_prod_s[31:0];
            3'b001, 3'b010:  w_fix = w_prod_s[63:32];
            3'b100, 3'b110:  w_fix = (r_b == 32'd0) ? 32'hFFFF_FFFF : w_quo;
            3'b101, 3'b111:  w_fix = (r_b == 32'd0) ? r_a : w_rem;
            default:         w_fix = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_cnt    <= 6'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_fix    <= 32'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op  <= op;
                r_a   <= src_a;
                r_b   <= src_b;
                r_cnt <= 6'd0;
                r_hi  <= 32'd0;
                r_lo  <= op[2] ? mag(src_a, op_signed(op)) : mag(src_b, op_signed(op));
            end else if (!flush) begin
                case (r_state)
                    S_CALC: begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_op[2]) begin
                            r_hi <= w_ge ? w_rsub : w_rshift[31:0];
                            r_lo <= {r_lo[30:0], w_ge};
                        end else begin
                            r_hi <= w_madd[32:1];
                            r_lo <= {w_madd[0], r_lo[31:1]};
                        end
                    end
                    S_FIX: r_fix <= w_fix;
                    S_DONE: begin
                        r_result <= r_fix;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule
